// File: rtl/retirement_expander.sv
// -----------------------------------------------------------------------------
// retirement_expander
//
// Replays one trace-encoder instruction block as one retired-instruction beat
// per cycle. This is the inverse of the multiple-retirement packer: a block
// gives the first PC and the number of half-words retired. Each instruction's
// size comes from a same-cycle lookup port that is fed by a program image or
// predecoder. The block sideband (itype, cause, tval, priv) is captured on
// accept and presented with every beat. itype is shown only on the last beat.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   valid_i / ready_o    block handshake; ready_o only while idle and not in reset
//   iaddr_i              address of first instruction in the block
//   iretire_i            half-words retired in the block
//   ilastsize_i          size of last instruction (1 = 32-bit, 0 = 16-bit)
//   itype_i, cause_i,
//   tval_i, priv_i       block sideband
//   lookup_addr_o        PC being sized (same as pc_o)
//   lookup_compressed_i  same-cycle answer: instruction at lookup_addr_o is 16-bit
//   valid_o / ready_i    beat handshake
//   pc_o, compressed_o   current instruction PC and size
//   last_o, empty_o      final beat of block / beat carries no instruction
//   itype_o              captured itype on the last beat, else 0
//   cause_o, tval_o,
//   priv_o               captured sideband, constant for the whole block
//   err_o                size mismatch detected on this (last) beat
//   err_sticky_o         any fired mismatch since reset
// -----------------------------------------------------------------------------
module retirement_expander #(
    parameter int XLEN        = 64,
    parameter int IRETIRE_LEN = 7,
    parameter int ITYPE_LEN   = 3,
    parameter int CAUSE_LEN   = 5,
    parameter int PRIV_LEN    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [XLEN-1:0]        iaddr_i,
    input  logic [IRETIRE_LEN-1:0] iretire_i,
    input  logic                   ilastsize_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [CAUSE_LEN-1:0]   cause_i,
    input  logic [XLEN-1:0]        tval_i,
    input  logic [PRIV_LEN-1:0]    priv_i,
    output logic [XLEN-1:0]        lookup_addr_o,
    input  logic                   lookup_compressed_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [XLEN-1:0]        pc_o,
    output logic                   compressed_o,
    output logic                   last_o,
    output logic                   empty_o,
    output logic [ITYPE_LEN-1:0]   itype_o,
    output logic [CAUSE_LEN-1:0]   cause_o,
    output logic [XLEN-1:0]        tval_o,
    output logic [PRIV_LEN-1:0]    priv_o,
    output logic                   err_o,
    output logic                   err_sticky_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [XLEN-1:0]        r_pc;
    logic [IRETIRE_LEN-1:0] r_rem;
    logic                   r_ilastsize;
    logic [ITYPE_LEN-1:0]   r_itype;
    logic [CAUSE_LEN-1:0]   r_cause;
    logic [XLEN-1:0]        r_tval;
    logic [PRIV_LEN-1:0]    r_priv;
    logic                   r_err_sticky;

    logic [IRETIRE_LEN-1:0] w_sz;       // current instruction size in half-words
    logic [XLEN-1:0]        w_pc_step;  // current instruction size in bytes
    logic                   w_last;
    logic                   w_err;
    logic                   w_accept;
    logic                   w_fire;

    // Size and mismatch terms depend only on the captured remainder and the
    // lookup answer, so they are valid for the whole time a beat is held.
    assign w_sz      = lookup_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    assign w_pc_step = lookup_compressed_i ? XLEN'(2) : XLEN'(4);
    assign w_last    = (r_rem <= w_sz);
    // Two mismatch cases are possible. In the first, a single half-word is left
    // but a 32-bit instruction is found. In the second, the last instruction
    // fills the remainder exactly, but its size disagrees with ilastsize.
    // Both cases imply rem <= sz, so a mismatch beat is always the last beat.
    assign w_err     = ((r_rem == IRETIRE_LEN'(1)) && !lookup_compressed_i) ||
                       ((r_rem == w_sz) && (lookup_compressed_i != !r_ilastsize));

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        valid_o      = 1'b0;
        compressed_o = 1'b0;
        last_o       = 1'b0;
        empty_o      = 1'b0;
        itype_o      = '0;
        err_o        = 1'b0;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // ready_o depends on state and reset only, never on ready_i.
                ready_o  = rst_ni;
                w_accept = valid_i && rst_ni;
                if (w_accept) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                // A beat is not offered while reset is asserted. This stops a
                // dropped block from completing a handshake in its final cycle.
                valid_o      = rst_ni;
                compressed_o = lookup_compressed_i;
                last_o       = w_last;
                empty_o      = (r_rem == '0);
                err_o        = w_err;
                itype_o      = w_last ? r_itype : '0;
                w_fire       = rst_ni && ready_i;
                if (w_fire && w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments, and reset is
    // sampled on the clock edge (synchronous), not in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc         <= '0;
            r_rem        <= '0;
            r_ilastsize  <= 1'b0;
            r_itype      <= '0;
            r_cause      <= '0;
            r_tval       <= '0;
            r_priv       <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pc        <= iaddr_i;
                r_rem       <= iretire_i;
                r_ilastsize <= ilastsize_i;
                r_itype     <= itype_i;
                r_cause     <= cause_i;
                r_tval      <= tval_i;
                r_priv      <= priv_i;
            end
            if (w_fire) begin
                // The PC wraps modulo 2^XLEN. On the last beat the remainder
                // may underflow, but it is overwritten on the next accept.
                r_pc  <= r_pc + w_pc_step;
                r_rem <= r_rem - w_sz;
                if (w_err) begin
                    r_err_sticky <= 1'b1;
                end
            end
        end
    end

    assign lookup_addr_o = r_pc;
    assign pc_o          = r_pc;
    assign cause_o       = r_cause;
    assign tval_o        = r_tval;
    assign priv_o        = r_priv;
    assign err_sticky_o  = r_err_sticky;

endmodule

// File: tb/tb_retirement_expander.sv
// -----------------------------------------------------------------------------
// tb_retirement_expander
//
// Self-checking bench for retirement_expander. The model expands each accepted
// block into its full list of expected beats, using the program-image lookup
// and the block rules. One compare process checks the DUT against the head of
// that list on every cycle. Directed blocks also pin the observed beats to
// hand-computed literals. A randomized phase follows, with random blocks, a
// random program image and random downstream stalls.
// -----------------------------------------------------------------------------
module tb_retirement_expander;

    localparam int XLEN        = 64;
    localparam int IRETIRE_LEN = 7;
    localparam int ITYPE_LEN   = 3;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   valid_i;
    logic                   ready_o;
    logic [XLEN-1:0]        iaddr_i;
    logic [IRETIRE_LEN-1:0] iretire_i;
    logic                   ilastsize_i;
    logic [ITYPE_LEN-1:0]   itype_i;
    logic [CAUSE_LEN-1:0]   cause_i;
    logic [XLEN-1:0]        tval_i;
    logic [PRIV_LEN-1:0]    priv_i;
    logic [XLEN-1:0]        lookup_addr_o;
    logic                   lookup_compressed_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [XLEN-1:0]        pc_o;
    logic                   compressed_o;
    logic                   last_o;
    logic                   empty_o;
    logic [ITYPE_LEN-1:0]   itype_o;
    logic [CAUSE_LEN-1:0]   cause_o;
    logic [XLEN-1:0]        tval_o;
    logic [PRIV_LEN-1:0]    priv_o;
    logic                   err_o;
    logic                   err_sticky_o;

    always #5 clk_i = ~clk_i;

    retirement_expander #(
        .XLEN(XLEN), .IRETIRE_LEN(IRETIRE_LEN), .ITYPE_LEN(ITYPE_LEN),
        .CAUSE_LEN(CAUSE_LEN), .PRIV_LEN(PRIV_LEN)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(valid_i), .ready_o(ready_o),
        .iaddr_i(iaddr_i), .iretire_i(iretire_i), .ilastsize_i(ilastsize_i),
        .itype_i(itype_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .lookup_addr_o(lookup_addr_o), .lookup_compressed_i(lookup_compressed_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .pc_o(pc_o), .compressed_o(compressed_o), .last_o(last_o), .empty_o(empty_o),
        .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
        .err_o(err_o), .err_sticky_o(err_sticky_o)
    );

    // Program image: mode 1 = all 16-bit, mode 2 = all 32-bit, otherwise a
    // 256-entry table indexed by half-word address bits.
    logic [1:0]   mode;
    logic [255:0] img;
    assign lookup_compressed_i = (mode == 2'd1) ? 1'b1 :
                                 (mode == 2'd2) ? 1'b0 : img[lookup_addr_o[8:1]];

    function automatic logic model_c(input logic [63:0] a);
        if (mode == 2'd1) return 1'b1;
        if (mode == 2'd2) return 1'b0;
        return img[a[8:1]];
    endfunction

    typedef struct packed {
        logic [63:0] pc;
        logic        c;
        logic        last;
        logic        empty;
        logic        err;
        logic [2:0]  itype;
        logic [4:0]  cause;
        logic [63:0] tval;
        logic [1:0]  priv;
    } beat_t;

    beat_t exp_q[$];   // beats the model still expects for the block in flight
    beat_t log_q[$];   // beats actually fired by the DUT
    logic  exp_sticky;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    rdy_mode = 0;  // 0 = always ready, 1 = random, 2 = stalled

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic beat_t log_at(input int i);
        beat_t z;
        z = '1;
        if (i < log_q.size()) z = log_q[i];
        return z;
    endfunction

    // Downstream ready, changed 2 time units after each rising edge.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            case (rdy_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = ($urandom_range(0, 3) != 0);
                default: ready_i = 1'b0;
            endcase
        end
    end

    // Compare process: sampled on the falling edge.
    always @(negedge clk_i) begin
        beat_t       b;
        logic [63:0] pc;
        int          rem;
        int          sz;
        logic        c;
        logic        was_idle;
        if (!rst_ni) begin
            check("rst_ready_o", ready_o, 1'b0);
            check("rst_valid_o", valid_o, 1'b0);
            exp_q.delete();
            exp_sticky = 1'b0;
        end else begin
            was_idle = (exp_q.size() == 0);
            check("ready_o", ready_o, was_idle);
            check("valid_o", valid_o, !was_idle);
            check("err_sticky_o", err_sticky_o, exp_sticky);
            if (was_idle) begin
                check("idle_itype_o", itype_o, 3'd0);
                check("idle_err_o", err_o, 1'b0);
            end else if (valid_o) begin
                b = exp_q[0];
                check("pc_o", pc_o, b.pc);
                check("lookup_addr_o", lookup_addr_o, b.pc);
                check("compressed_o", compressed_o, b.c);
                check("last_o", last_o, b.last);
                check("empty_o", empty_o, b.empty);
                check("err_o", err_o, b.err);
                check("itype_o", itype_o, b.itype);
                check("cause_o", cause_o, b.cause);
                check("tval_o", tval_o, b.tval);
                check("priv_o", priv_o, b.priv);
                if (ready_i) begin
                    log_q.push_back('{pc_o, compressed_o, last_o, empty_o, err_o,
                                      itype_o, cause_o, tval_o, priv_o});
                    if (b.err) exp_sticky = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            // A block accepted at the coming edge: expand it into its beats.
            if (valid_i && was_idle) begin
                pc  = iaddr_i;
                rem = int'(iretire_i);
                for (int k = 0; k < 200; k++) begin
                    c       = model_c(pc);
                    sz      = c ? 1 : 2;
                    b.pc    = pc;
                    b.c     = c;
                    b.empty = (rem == 0);
                    b.last  = (rem <= sz);
                    b.err   = ((rem == 1) && !c) || ((rem == sz) && (c != !ilastsize_i));
                    b.itype = b.last ? itype_i : 3'd0;
                    b.cause = cause_i;
                    b.tval  = tval_i;
                    b.priv  = priv_i;
                    exp_q.push_back(b);
                    if (b.last) break;
                    pc  = pc + 64'(2 * sz);
                    rem = rem - sz;
                end
            end
        end
    end

    task automatic send_block(input logic [63:0] a, input int ret, input logic ls,
                              input logic [2:0] it, input logic [4:0] ca,
                              input logic [63:0] tv, input logic [1:0] pr);
        logic ok;
        @(posedge clk_i);
        #1;
        iaddr_i     = a;
        iretire_i   = 7'(ret);
        ilastsize_i = ls;
        itype_i     = it;
        cause_i     = ca;
        tval_i      = tv;
        priv_i      = pr;
        valid_i     = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("block_accepted", ok, 1'b1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_ni      = 1'b0;
        valid_i     = 1'b0;
        iaddr_i     = '0;
        iretire_i   = '0;
        ilastsize_i = 1'b0;
        itype_i     = '0;
        cause_i     = '0;
        tval_i      = '0;
        priv_i      = '0;
        mode        = 2'd0;
        img         = '0;
        exp_sticky  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("reset_pc_o", pc_o, 64'd0);
        check("reset_lookup_addr_o", lookup_addr_o, 64'd0);
        check("reset_itype_o", itype_o, 3'd0);
        check("reset_err_o", err_o, 1'b0);
        check("reset_err_sticky_o", err_sticky_o, 1'b0);
        check("reset_tval_o", tval_o, 64'd0);
        check("reset_cause_o", cause_o, 5'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Mixed sizes: C,32,C,32 starting at 0x1000, 6 half-words.
        img[0] = 1'b1; img[1] = 1'b0; img[3] = 1'b1; img[4] = 1'b0;
        log_q.delete();
        send_block(64'h1000, 6, 1'b1, 3'd0, 5'd0, 64'd0, 2'd0);
        wait_idle();
        check("mix_beats", log_q.size(), 4);
        check("mix_pc0", log_at(0).pc, 64'h1000);
        check("mix_pc1", log_at(1).pc, 64'h1002);
        check("mix_pc2", log_at(2).pc, 64'h1006);
        check("mix_pc3", log_at(3).pc, 64'h1008);
        check("mix_last2", log_at(2).last, 1'b0);
        check("mix_last3", log_at(3).last, 1'b1);
        check("mix_err3", log_at(3).err, 1'b0);

        // Empty exception block.
        log_q.delete();
        send_block(64'h5000, 0, 1'b0, 3'd1, 5'd2, 64'hdead, 2'd3);
        wait_idle();
        check("empty_beats", log_q.size(), 1);
        check("empty_pc", log_at(0).pc, 64'h5000);
        check("empty_flag", log_at(0).empty, 1'b1);
        check("empty_last", log_at(0).last, 1'b1);
        check("empty_itype", log_at(0).itype, 3'd1);
        check("empty_cause", log_at(0).cause, 5'd2);
        check("empty_tval", log_at(0).tval, 64'hdead);

        // Downstream stall on the second beat of a 4 x 32-bit block.
        mode = 2'd2;
        log_q.delete();
        send_block(64'h2000, 8, 1'b1, 3'd2, 5'd0, 64'd0, 2'd1);
        @(posedge clk_i);
        #1;
        rdy_mode = 2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("hold_pc_o", pc_o, 64'h2004);
            check("hold_valid_o", valid_o, 1'b1);
            check("hold_ready_o", ready_o, 1'b0);
        end
        rdy_mode = 0;
        wait_idle();
        check("hold_beats", log_q.size(), 4);
        check("hold_pc1", log_at(1).pc, 64'h2004);
        check("hold_pc3", log_at(3).pc, 64'h200C);
        check("hold_last3", log_at(3).last, 1'b1);
        check("hold_itype3", log_at(3).itype, 3'd2);

        // PC wrap with all 16-bit instructions.
        mode = 2'd1;
        log_q.delete();
        send_block(64'hFFFF_FFFF_FFFF_FFFE, 3, 1'b0, 3'd0, 5'd0, 64'd0, 2'd0);
        wait_idle();
        check("wrap_beats", log_q.size(), 3);
        check("wrap_pc0", log_at(0).pc, 64'hFFFF_FFFF_FFFF_FFFE);
        check("wrap_pc1", log_at(1).pc, 64'h0);
        check("wrap_pc2", log_at(2).pc, 64'h2);
        check("wrap_last1", log_at(1).last, 1'b0);
        check("wrap_last2", log_at(2).last, 1'b1);

        // Size mismatch: 3 half-words, all 32-bit.
        mode = 2'd2;
        log_q.delete();
        send_block(64'h4000, 3, 1'b1, 3'd0, 5'd0, 64'd0, 2'd0);
        wait_idle();
        check("err_beats", log_q.size(), 2);
        check("err_beat0", log_at(0).err, 1'b0);
        check("err_beat1", log_at(1).err, 1'b1);
        check("err_last1", log_at(1).last, 1'b1);
        check("err_sticky_after", err_sticky_o, 1'b1);
        log_q.delete();
        send_block(64'h4100, 4, 1'b1, 3'd0, 5'd0, 64'd0, 2'd0);
        wait_idle();
        check("post_err_beats", log_q.size(), 2);

        // Reset during the second beat of a 4-beat block.
        log_q.delete();
        send_block(64'h3000, 8, 1'b1, 3'd0, 5'd0, 64'd0, 2'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_mid_valid_o", valid_o, 1'b0);
        check("rst_mid_ready_o", ready_o, 1'b1);
        check("rst_mid_pc_o", pc_o, 64'd0);
        check("rst_mid_sticky", err_sticky_o, 1'b0);
        check("rst_mid_beats", log_q.size(), 1);

        // Randomized blocks, image and downstream stalls.
        rdy_mode = 1;
        mode     = 2'd0;
        img      = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 60; i++) begin
            if (i % 20 == 19) begin
                wait_idle();
                mode = 2'($urandom_range(0, 2));
                img  = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
            end
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            send_block({$urandom, $urandom},
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127))
                                                   : int'($urandom_range(0, 12)),
                       1'($urandom), 3'($urandom), 5'($urandom),
                       {$urandom, $urandom}, 2'($urandom));
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
